mult_control_unit: RTL and testbench

- Control FSM that sequences the multiplier datapath (`datapathunit`) through one operation:
  - captures operand A, then operand B, from the 8-bit switch bus on debounced `enter` presses;
  - starts the multiplier and waits for its completion;
  - selects what the four 7-segment displays show.
- Sits beside `datapathunit` in the top level. It drives `loaddata`, `opsel`, `mult_start` and `disp_sel`. It consumes `inputdata_ready` and `mult_done`.

---
 rtl/mult_control_unit.sv | 161 ++++++++++++++++
 tb/tb_mult_control_unit.sv | 320 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mult_control_unit.sv
// mult_control_unit
//   Control FSM for the multiplier datapath. It captures operand A and then
//   operand B from the switch bus on debounced enter presses, starts the
//   multiplier, waits for completion (with a timeout), and selects what the
//   7-segment displays show.
//
// Ports
//   clk              system clock, rising edge
//   reset            asynchronous, active-high reset
//   enter            raw pushbutton, active-high, asynchronous to clk
//   inputdata_ready  datapath can accept an operand this cycle
//   mult_done        multiplier result valid (sampled only in WAIT)
//   loaddata         one-cycle pulse: datapath captures the operand picked by opsel
//   opsel            0 = operand A, 1 = operand B
//   mult_start       one-cycle pulse starting the multiplication
//   disp_sel         00 live input, 01 operand A, 10 error code, 11 product
//   busy             high in START and WAIT
//   error            high in ERR
module mult_control_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned MAX_WAIT        = 32
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enter,
  input  logic       inputdata_ready,
  input  logic       mult_done,
  output logic       loaddata,
  output logic       opsel,
  output logic       mult_start,
  output logic [1:0] disp_sel,
  output logic       busy,
  output logic       error
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int unsigned TW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(MAX_WAIT - 1);

  localparam logic [2:0] ST_GET_A  = 3'd0;
  localparam logic [2:0] ST_LOAD_A = 3'd1;
  localparam logic [2:0] ST_GET_B  = 3'd2;
  localparam logic [2:0] ST_LOAD_B = 3'd3;
  localparam logic [2:0] ST_START  = 3'd4;
  localparam logic [2:0] ST_WAIT   = 3'd5;
  localparam logic [2:0] ST_SHOW   = 3'd6;
  localparam logic [2:0] ST_ERR    = 3'd7;

  logic          s1_q, s2_q;
  logic          deb_q, deb_d;
  logic          deb_dly_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [2:0]    state_q, state_d;
  logic          enter_evt;

  // Debounce: the level only follows s2 after it has differed for
  // DEBOUNCE_CYCLES consecutive edges; any agreement restarts the count.
  always_comb begin
    deb_d = deb_q;
    cnt_d = '0;
    if (s2_q != deb_q) begin
      if (cnt_q == CNT_LAST) begin
        deb_d = s2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign enter_evt = deb_q & ~deb_dly_q;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_GET_A:  if (enter_evt && inputdata_ready) state_d = ST_LOAD_A;
      ST_LOAD_A: state_d = ST_GET_B;
      ST_GET_B:  if (enter_evt && inputdata_ready) state_d = ST_LOAD_B;
      ST_LOAD_B: state_d = ST_START;
      ST_START:  state_d = ST_WAIT;
      ST_WAIT: begin
        // Completion takes priority over a timeout in the same cycle.
        if (mult_done)                  state_d = ST_SHOW;
        else if (timer_q == TIMER_LAST) state_d = ST_ERR;
      end
      ST_SHOW:   if (enter_evt) state_d = ST_GET_A;
      ST_ERR:    if (enter_evt) state_d = ST_GET_A;
      default:   state_d = ST_GET_A;
    endcase
  end

  // The timer holds at its last value instead of wrapping; WAIT is left at
  // that value anyway.
  always_comb begin
    timer_d = timer_q;
    if (state_q == ST_START) begin
      timer_d = '0;
    end else if (state_q == ST_WAIT && timer_q != TIMER_LAST) begin
      timer_d = timer_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      deb_q     <= 1'b0;
      deb_dly_q <= 1'b0;
      cnt_q     <= '0;
      timer_q   <= '0;
      state_q   <= ST_GET_A;
    end else begin
      s1_q      <= enter;
      s2_q      <= s1_q;
      deb_q     <= deb_d;
      deb_dly_q <= deb_q;
      cnt_q     <= cnt_d;
      timer_q   <= timer_d;
      state_q   <= state_d;
    end
  end

  always_comb begin
    loaddata   = 1'b0;
    opsel      = 1'b0;
    mult_start = 1'b0;
    disp_sel   = 2'b00;
    busy       = 1'b0;
    error      = 1'b0;
    unique case (state_q)
      ST_GET_A:  ;
      ST_LOAD_A: loaddata = 1'b1;
      ST_GET_B: begin
        opsel    = 1'b1;
        disp_sel = 2'b01;
      end
      ST_LOAD_B: begin
        loaddata = 1'b1;
        opsel    = 1'b1;
        disp_sel = 2'b01;
      end
      ST_START: begin
        mult_start = 1'b1;
        busy       = 1'b1;
        disp_sel   = 2'b01;
      end
      ST_WAIT: begin
        busy     = 1'b1;
        disp_sel = 2'b01;
      end
      ST_SHOW:   disp_sel = 2'b11;
      ST_ERR: begin
        error    = 1'b1;
        disp_sel = 2'b10;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mult_control_unit.sv
module tb_mult_control_unit;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enter = 1'b0;
  logic       inputdata_ready = 1'b1;
  logic       mult_done = 1'b0;
  logic       loaddata, opsel, mult_start, busy, error;
  logic [1:0] disp_sel;

  int checks = 0;
  int errors = 0;
  int ms_cnt = 0;
  bit exp_ld[$];

  mult_control_unit #(.DEBOUNCE_CYCLES(4), .MAX_WAIT(32)) dut (
    .clk(clk), .reset(reset), .enter(enter),
    .inputdata_ready(inputdata_ready), .mult_done(mult_done),
    .loaddata(loaddata), .opsel(opsel), .mult_start(mult_start),
    .disp_sel(disp_sel), .busy(busy), .error(error)
  );

  always #5 clk = ~clk;

  // Scoreboard: every loaddata pulse must match the next expected operand select.
  always @(posedge clk) begin
    #1;
    if (loaddata === 1'b1) begin
      checks++;
      if (exp_ld.size() == 0) begin
        errors++;
        $display("FAIL ld_unexpected: loaddata=1 opsel=%b, required no pulse", opsel);
      end else begin
        bit e;
        e = exp_ld.pop_front();
        if (opsel !== e) begin
          errors++;
          $display("FAIL ld_opsel: opsel=%b required %b", opsel, e);
        end
      end
    end
    if (mult_start === 1'b1) ms_cnt++;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    enter = 1'b0;
    mult_done = 1'b0;
    inputdata_ready = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    repeat (2) tick();
  endtask

  task automatic press(input int hold);
    enter = 1'b1;
    repeat (hold) tick();
    enter = 1'b0;
    repeat (12) tick();
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      tick();
      if (mult_start === 1'b1) ok = 1'b1;
    end
  endtask

  task automatic test_reset();
    tick();
    checks++;
    if ({loaddata, opsel, mult_start, disp_sel, busy, error} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0000000",
               {loaddata, opsel, mult_start, disp_sel, busy, error});
    end
    // Button held through reset release: exactly one event.
    enter = 1'b1;
    repeat (2) tick();
    exp_ld.push_back(1'b0);
    reset = 1'b0;
    repeat (20) tick();
    checks++;
    if (disp_sel !== 2'b01) begin
      errors++;
      $display("FAIL reset_held_disp: disp_sel=%b required 01", disp_sel);
    end
    enter = 1'b0;
    repeat (12) tick();
    checks++;
    if (exp_ld.size() != 0) begin
      errors++;
      $display("FAIL reset_held_ld: pending=%0d required 0", exp_ld.size());
    end
  endtask

  task automatic test_glitch();
    do_reset();
    enter = 1'b1;
    repeat (3) tick();
    enter = 1'b0;
    repeat (15) tick();
    checks++;
    if (disp_sel !== 2'b00) begin
      errors++;
      $display("FAIL glitch_disp: disp_sel=%b required 00", disp_sel);
    end
  endtask

  task automatic test_debounce_timing();
    int hits;
    do_reset();
    hits = 0;
    exp_ld.push_back(1'b0);
    enter = 1'b1;
    for (int k = 0; k < 10; k++) begin
      tick();
      if (loaddata === 1'b1) begin
        hits++;
        checks++;
        if (k != 6) begin
          errors++;
          $display("FAIL deb_timing: loaddata after edge %0d required edge 6", k);
        end
      end
    end
    enter = 1'b0;
    repeat (12) tick();
    checks++;
    if (hits != 1) begin
      errors++;
      $display("FAIL deb_count: pulses=%0d required 1", hits);
    end
  endtask

  task automatic test_full_op();
    bit ok;
    int bc, ms0;
    do_reset();
    ms0 = ms_cnt;
    exp_ld.push_back(1'b0);
    press(10);
    checks++;
    if (disp_sel !== 2'b01) begin
      errors++;
      $display("FAIL full_get_b_disp: disp_sel=%b required 01", disp_sel);
    end
    exp_ld.push_back(1'b1);
    enter = 1'b1;
    wait_start(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL full_start_timeout: mult_start not seen within 40 cycles");
    end
    bc = (busy === 1'b1) ? 1 : 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (busy === 1'b1) bc++;
    end
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    checks++;
    if (bc != 7 || busy !== 1'b0) begin
      errors++;
      $display("FAIL full_busy: busy cycles=%0d busy_now=%b required 7 and 0", bc, busy);
    end
    checks++;
    if (disp_sel !== 2'b11) begin
      errors++;
      $display("FAIL full_show: disp_sel=%b required 11", disp_sel);
    end
    enter = 1'b0;
    mult_done = 1'b1;
    repeat (12) tick();
    checks++;
    if (ms_cnt - ms0 != 1) begin
      errors++;
      $display("FAIL full_mstart: pulses=%0d required 1", ms_cnt - ms0);
    end
    // Done held high across SHOW -> GET_A must not matter.
    press(10);
    mult_done = 1'b0;
    checks++;
    if (disp_sel !== 2'b00 || exp_ld.size() != 0) begin
      errors++;
      $display("FAIL full_return: disp_sel=%b pending=%0d required 00 and 0",
               disp_sel, exp_ld.size());
    end
  endtask

  task automatic test_not_ready();
    do_reset();
    inputdata_ready = 1'b0;
    press(10);
    checks++;
    if (disp_sel !== 2'b00) begin
      errors++;
      $display("FAIL notready_disp: disp_sel=%b required 00", disp_sel);
    end
    inputdata_ready = 1'b1;
    exp_ld.push_back(1'b0);
    press(10);
    checks++;
    if (exp_ld.size() != 0 || disp_sel !== 2'b01) begin
      errors++;
      $display("FAIL notready_load: pending=%0d disp_sel=%b required 0 and 01",
               exp_ld.size(), disp_sel);
    end
  endtask

  task automatic to_start(output bit ok);
    do_reset();
    exp_ld.push_back(1'b0);
    press(10);
    exp_ld.push_back(1'b1);
    enter = 1'b1;
    wait_start(ok);
    enter = 1'b0;
  endtask

  task automatic test_timeout();
    bit ok;
    int n;
    to_start(ok);
    n = 0;
    for (int i = 0; i < 60 && error !== 1'b1; i++) begin
      tick();
      n++;
    end
    checks++;
    if (!ok || n != 33) begin
      errors++;
      $display("FAIL timeout_cycles: start_seen=%0d cycles_to_err=%0d required 1 and 33", ok, n);
    end
    checks++;
    if (disp_sel !== 2'b10 || busy !== 1'b0) begin
      errors++;
      $display("FAIL timeout_disp: disp_sel=%b busy=%b required 10 and 0", disp_sel, busy);
    end
    press(10);
    checks++;
    if (error !== 1'b0 || disp_sel !== 2'b00) begin
      errors++;
      $display("FAIL timeout_exit: error=%b disp_sel=%b required 0 and 00", error, disp_sel);
    end
  endtask

  task automatic test_done_at_timeout();
    bit ok;
    to_start(ok);
    repeat (32) tick();
    checks++;
    if (!ok || busy !== 1'b1) begin
      errors++;
      $display("FAIL edge_wait: start_seen=%0d busy=%b required 1 and 1", ok, busy);
    end
    mult_done = 1'b1;
    tick();
    mult_done = 1'b0;
    checks++;
    if (disp_sel !== 2'b11 || error !== 1'b0) begin
      errors++;
      $display("FAIL edge_show: disp_sel=%b error=%b required 11 and 0", disp_sel, error);
    end
  endtask

  task automatic test_reset_in_wait();
    bit ok;
    int ms0;
    to_start(ok);
    repeat (3) tick();
    ms0 = ms_cnt;
    #2 reset = 1'b1;
    #1;
    checks++;
    if (busy !== 1'b0 || mult_start !== 1'b0 || loaddata !== 1'b0 || disp_sel !== 2'b00) begin
      errors++;
      $display("FAIL rst_wait_async: busy=%b ms=%b ld=%b disp=%b required 0 0 0 00",
               busy, mult_start, loaddata, disp_sel);
    end
    tick();
    reset = 1'b0;
    mult_done = 1'b1;
    repeat (5) tick();
    mult_done = 1'b0;
    repeat (10) tick();
    checks++;
    if (disp_sel !== 2'b00 || busy !== 1'b0 || ms_cnt != ms0) begin
      errors++;
      $display("FAIL rst_wait_after: disp=%b busy=%b extra_starts=%0d required 00 0 0",
               disp_sel, busy, ms_cnt - ms0);
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_debounce_timing();
    test_full_op();
    test_not_ready();
    test_timeout();
    test_done_at_timeout();
    test_reset_in_wait();
    checks++;
    if (exp_ld.size() != 0) begin
      errors++;
      $display("FAIL ld_missing: pending=%0d required 0", exp_ld.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
